// File: rtl/router_pkg.sv
// router_pkg: shared parameter defaults and channel packing helpers for the
// router_sync slice.
// Contents:
//   W_CHAN_DEF / W_SEL_DEF / N_IN_DEF / N_OUT_DEF - default parameter values
//   chan_lsb()                                    - LSB index of channel k in a packed bus
package router_pkg;

    localparam int W_CHAN_DEF = 16;
    localparam int W_SEL_DEF  = 4;
    localparam int N_IN_DEF   = 8;
    localparam int N_OUT_DEF  = 8;

    // Channel k of a packed bus occupies bits [k*w +: w].
    function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/router_sync_if.sv
// router_sync_if: bundles the router's data, configuration and status signals.
// Modports:
//   master - drives input channels and configuration, observes routed outputs
//   slave  - the router itself
// Signals:
//   data_bus_in/data_valid_in          packed input channels and strobes
//   src/dest_select_in, output_active_in, write_en_in, commit_in  table config
//   data_bus_out/data_valid_out        packed routed outputs and strobes
//   cfg_error_out                      sticky out-of-range write flag
interface router_sync_if #(
    parameter int W_CHAN = 16,
    parameter int W_SEL  = 4,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 8
);
    logic [W_CHAN*N_IN-1:0]  data_bus_in;
    logic [N_IN-1:0]         data_valid_in;
    logic [W_SEL-1:0]        src_select_in;
    logic [W_SEL-1:0]        dest_select_in;
    logic [N_OUT-1:0]        output_active_in;
    logic                    write_en_in;
    logic                    commit_in;
    logic [W_CHAN*N_OUT-1:0] data_bus_out;
    logic [N_OUT-1:0]        data_valid_out;
    logic                    cfg_error_out;

    modport master (
        output data_bus_in, data_valid_in, src_select_in, dest_select_in,
               output_active_in, write_en_in, commit_in,
        input  data_bus_out, data_valid_out, cfg_error_out
    );

    modport slave (
        input  data_bus_in, data_valid_in, src_select_in, dest_select_in,
               output_active_in, write_en_in, commit_in,
        output data_bus_out, data_valid_out, cfg_error_out
    );
endinterface

// File: rtl/mux_n_chan.sv
// mux_n_chan: combinational N_IN:1 channel selector for data and valid.
// Ports:
//   data_bus_in  packed input channels (W_CHAN*N_IN)
//   valid_in     per-channel valid strobes
//   sel_in       channel index; out-of-range selects yield zero / invalid
//   data_out     selected channel data
//   valid_out    selected channel valid
module mux_n_chan
    import router_pkg::*;
#(
    parameter int W_CHAN = W_CHAN_DEF,
    parameter int W_SEL  = W_SEL_DEF,
    parameter int N_IN   = N_IN_DEF
) (
    input  logic [W_CHAN*N_IN-1:0] data_bus_in,
    input  logic [N_IN-1:0]        valid_in,
    input  logic [W_SEL-1:0]       sel_in,
    output logic [W_CHAN-1:0]      data_out,
    output logic                   valid_out
);

    always_comb begin
        data_out  = '0;
        valid_out = 1'b0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (W_SEL'(k) == sel_in) begin
                data_out  = data_bus_in[chan_lsb(k, W_CHAN) +: W_CHAN];
                valid_out = valid_in[k];
            end
        end
    end

endmodule

// File: rtl/router_sync.sv
// router_sync: registered N_IN x N_OUT channel router with double-buffered
// (shadow/live) routing table and a one-cycle routing latency.
// Ports:
//   clk_in  single clock, rising edge
//   rst_in  synchronous active-high reset; beats write/commit in the same cycle
//   bus     router_sync_if.slave: input channels, table config, routed outputs
module router_sync
    import router_pkg::*;
#(
    parameter int W_CHAN = W_CHAN_DEF,
    parameter int W_SEL  = W_SEL_DEF,
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    router_sync_if.slave  bus
);

    localparam logic [W_SEL:0] N_IN_L  = (W_SEL+1)'(N_IN);
    localparam logic [W_SEL:0] N_OUT_L = (W_SEL+1)'(N_OUT);

    logic [W_SEL-1:0]        shadow_src_q [N_OUT];
    logic [W_SEL-1:0]        shadow_src_d [N_OUT];
    logic [N_OUT-1:0]        shadow_mask_q, shadow_mask_d;
    logic [W_SEL-1:0]        live_src_q   [N_OUT];
    logic [N_OUT-1:0]        live_mask_q;
    logic                    err_q, err_d;
    logic [W_CHAN*N_OUT-1:0] data_q;
    logic [N_OUT-1:0]        valid_q;

    logic                    wr_ok;
    logic [W_CHAN-1:0]       mux_data [N_OUT];
    logic [N_OUT-1:0]        mux_valid;

    assign wr_ok = ({1'b0, bus.dest_select_in} < N_OUT_L) &&
                   ({1'b0, bus.src_select_in}  < N_IN_L);

    // Shadow next-state is also what a commit copies, so a write and commit
    // in the same cycle land together in the live table.
    always_comb begin
        shadow_src_d  = shadow_src_q;
        shadow_mask_d = shadow_mask_q;
        err_d         = err_q;
        if (bus.write_en_in) begin
            if (wr_ok) begin
                for (int unsigned j = 0; j < N_OUT; j++) begin
                    if (W_SEL'(j) == bus.dest_select_in) begin
                        shadow_src_d[j] = bus.src_select_in;
                    end
                end
                shadow_mask_d = bus.output_active_in;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_mux
        mux_n_chan #(
            .W_CHAN (W_CHAN),
            .W_SEL  (W_SEL),
            .N_IN   (N_IN)
        ) u_mux (
            .data_bus_in (bus.data_bus_in),
            .valid_in    (bus.data_valid_in),
            .sel_in      (live_src_q[g]),
            .data_out    (mux_data[g]),
            .valid_out   (mux_valid[g])
        );
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_src_q  <= '{default: '0};
            shadow_mask_q <= '0;
            live_src_q    <= '{default: '0};
            live_mask_q   <= '0;
            err_q         <= 1'b0;
            data_q        <= '0;
            valid_q       <= '0;
        end else begin
            shadow_src_q  <= shadow_src_d;
            shadow_mask_q <= shadow_mask_d;
            err_q         <= err_d;
            if (bus.commit_in) begin
                live_src_q  <= shadow_src_d;
                live_mask_q <= shadow_mask_d;
            end
            // Routing uses the live table as it stood before any commit this cycle.
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (!live_mask_q[j]) begin
                    data_q[chan_lsb(j, W_CHAN) +: W_CHAN] <= '0;
                    valid_q[j]                            <= 1'b0;
                end else if (mux_valid[j]) begin
                    data_q[chan_lsb(j, W_CHAN) +: W_CHAN] <= mux_data[j];
                    valid_q[j]                            <= 1'b1;
                end else begin
                    valid_q[j]                            <= 1'b0;
                end
            end
        end
    end

    assign bus.data_bus_out   = data_q;
    assign bus.data_valid_out = valid_q;
    assign bus.cfg_error_out  = err_q;

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: scoreboard bench for router_sync. The driver computes each
// cycle's expected outputs from a table-level reference model and queues them;
// a monitor pops and compares after every rising edge.
module tb_router_sync;

    localparam int WC = 16;
    localparam int WS = 4;
    localparam int NI = 8;
    localparam int NO = 8;

    typedef struct {
        logic [WC*NO-1:0] data;
        logic [NO-1:0]    valid;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;
    router_sync_if #(.W_CHAN(WC), .W_SEL(WS), .N_IN(NI), .N_OUT(NO)) bus ();

    router_sync #(.W_CHAN(WC), .W_SEL(WS), .N_IN(NI), .N_OUT(NO)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    // Reference model state: routing tables as plain integer arrays.
    int          m_shadow_src [NO];
    int          m_live_src   [NO];
    logic [7:0]  m_shadow_mask;
    logic [7:0]  m_live_mask;
    bit          m_err;
    logic [15:0] m_out   [NO];
    logic [7:0]  m_out_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] put(input logic [127:0] b, input int k, input logic [15:0] v);
        logic [127:0] r;
        r = b;
        r[k*16 +: 16] = v;
        return r;
    endfunction

    task automatic model_step(input bit r, input bit we, input int src, input int dest,
                              input logic [7:0] mask, input bit cm,
                              input logic [7:0] vin, input logic [127:0] dbus);
        exp_t e;
        if (r) begin
            for (int j = 0; j < NO; j++) begin
                m_shadow_src[j] = 0;
                m_live_src[j]   = 0;
                m_out[j]        = 16'h0;
            end
            m_shadow_mask = 8'h00;
            m_live_mask   = 8'h00;
            m_err         = 1'b0;
            m_out_v       = 8'h00;
        end else begin
            for (int j = 0; j < NO; j++) begin
                int s;
                s = m_live_src[j];
                if (!m_live_mask[j]) begin
                    m_out[j]   = 16'h0;
                    m_out_v[j] = 1'b0;
                end else if (vin[s]) begin
                    m_out[j]   = dbus[s*16 +: 16];
                    m_out_v[j] = 1'b1;
                end else begin
                    m_out_v[j] = 1'b0;
                end
            end
            if (we) begin
                if (src < NI && dest < NO) begin
                    m_shadow_src[dest] = src;
                    m_shadow_mask      = mask;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (cm) begin
                m_live_src  = m_shadow_src;
                m_live_mask = m_shadow_mask;
            end
        end
        e.data = '0;
        for (int j = 0; j < NO; j++) e.data[j*16 +: 16] = m_out[j];
        e.valid = m_out_v;
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    // One clock cycle: drive at negedge, queue expectation, return at posedge+2.
    task automatic cyc(input bit r, input bit we, input int src, input int dest,
                       input logic [7:0] mask, input bit cm,
                       input logic [7:0] vin, input logic [127:0] dbus);
        @(negedge clk);
        rst                  = r;
        bus.write_en_in      = we;
        bus.src_select_in    = 4'(src);
        bus.dest_select_in   = 4'(dest);
        bus.output_active_in = mask;
        bus.commit_in        = cm;
        bus.data_valid_in    = vin;
        bus.data_bus_in      = dbus;
        model_step(r, we, src, dest, mask, cm, vin, dbus);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] out_ch(input int k);
        logic [127:0] b;
        b = bus.data_bus_out;
        return b[k*16 +: 16];
    endfunction

    // Monitor: compare every registered output against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_valid", 128'(bus.data_valid_out), 128'(e.valid));
                check_eq("sb_data",  128'(bus.data_bus_out),   128'(e.data));
                check_eq("sb_err",   128'(bus.cfg_error_out),  128'(e.err));
            end
        end
    end

    initial begin
        logic [127:0] d;
        rst = 1'b1;
        bus.write_en_in = 1'b0; bus.commit_in = 1'b0;
        bus.src_select_in = '0; bus.dest_select_in = '0; bus.output_active_in = '0;
        bus.data_valid_in = '0; bus.data_bus_in = '0;

        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, '0);
        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, '0);

        // No table written: nothing is routed.
        d = put('0, 0, 16'h1234);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h01, d);
        check_eq("reset_valid", 128'(bus.data_valid_out), 128'h00);
        check_eq("reset_data", bus.data_bus_out, 128'h0);
        check_eq("reset_err", 128'(bus.cfg_error_out), 128'h0);

        // in3 -> out5
        cyc(0, 1, 3, 5, 8'h20, 0, 8'h00, '0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, '0);
        d = put('0, 3, 16'hBEEF);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h08, d);
        check_eq("route_out5", 128'(out_ch(5)), 128'hBEEF);
        check_eq("route_valid", 128'(bus.data_valid_out), 128'h20);

        // Write without commit is invisible; commit makes it live.
        cyc(0, 1, 2, 1, 8'h02, 0, 8'h00, '0);
        d = put('0, 2, 16'h5555);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h04, d);
        check_eq("nocommit_valid", 128'(bus.data_valid_out), 128'h00);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, '0);
        d = put('0, 2, 16'h7777);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h04, d);
        check_eq("commit_out1", 128'(out_ch(1)), 128'h7777);
        check_eq("commit_valid", 128'(bus.data_valid_out), 128'h02);

        // Out-of-range source: sticky error, shadow untouched.
        cyc(0, 1, 9, 0, 8'hFF, 0, 8'h00, '0);
        check_eq("err_set", 128'(bus.cfg_error_out), 128'h1);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, '0);
        d = put('0, 2, 16'h0101);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hFF, d);
        check_eq("err_shadow_kept", 128'(bus.data_valid_out), 128'h02);
        check_eq("err_sticky", 128'(bus.cfg_error_out), 128'h1);
        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, '0);
        check_eq("err_cleared", 128'(bus.cfg_error_out), 128'h0);

        // Fan-out: in4 -> out0 and out7.
        cyc(0, 1, 4, 0, 8'h81, 0, 8'h00, '0);
        cyc(0, 1, 4, 7, 8'h81, 0, 8'h00, '0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, '0);
        d = put('0, 4, 16'h00AA);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h10, d);
        check_eq("fan_out0", 128'(out_ch(0)), 128'h00AA);
        check_eq("fan_out7", 128'(out_ch(7)), 128'h00AA);
        check_eq("fan_valid", 128'(bus.data_valid_out), 128'h81);

        // Write+commit with a live sample: sample uses the old table.
        d = put(put('0, 4, 16'h1111), 1, 16'h9999);
        cyc(0, 1, 1, 0, 8'h01, 1, 8'h12, d);
        check_eq("wc_old_out0", 128'(out_ch(0)), 128'h1111);
        check_eq("wc_old_valid", 128'(bus.data_valid_out), 128'h81);
        d = put(put('0, 4, 16'h3333), 1, 16'h2222);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h12, d);
        check_eq("wc_new_out0", 128'(out_ch(0)), 128'h2222);
        check_eq("wc_new_out7", 128'(out_ch(7)), 128'h0000);
        check_eq("wc_new_valid", 128'(bus.data_valid_out), 128'h01);

        // Reset mid-stream, even with write/commit asserted.
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hFF, {4{32'hA5A5_5A5A}});
        cyc(1, 1, 1, 1, 8'hFF, 1, 8'hFF, {4{32'hDEAD_BEEF}});
        check_eq("rst_mid_valid", 128'(bus.data_valid_out), 128'h00);
        check_eq("rst_mid_data", bus.data_bus_out, 128'h0);

        // Randomised traffic and configuration.
        for (int i = 0; i < 400; i++) begin
            bit r, we, cm;
            int src, dest;
            r    = ($urandom_range(0, 59) == 0);
            we   = ($urandom_range(0, 3) == 0);
            cm   = ($urandom_range(0, 5) == 0);
            src  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
            dest = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
            d    = {$urandom, $urandom, $urandom, $urandom};
            cyc(r, we, src, dest, 8'($urandom), cm, 8'($urandom), d);
        end

        cyc(0, 0, 0, 0, 8'h00, 0, 8'h00, '0);
        @(posedge clk);
        #2;
        check_eq("sb_drain", 128'(sb_q.size()), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
